fp_compare_pipe: RTL and testbench
==================================

Name: fp_compare_pipe

Overview:
- Parametrised, pipelined IEEE-754 floating-point comparator. It is the successor to the fixed single-precision greater-or-equal operator.
- Format width is configurable through the exponent and mantissa parameters. The predicate is selected per transaction.
- Fully IEEE-compliant handling of NaN, signed zero, infinity and subnormals.
- Uses a valid/ready handshake on input and output, so it drops into streaming datapaths alongside the other fp_operation blocks.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa (fraction) field width; operand width FP_W = 1+EXP_W+MAN_W.
- LATENCY, 2, pipeline stages from input acceptance to output valid; legal range >=1.
- RESULT_W, 32, width of m_result; the boolean result sits in bit 0 and is zero-extended.

Ports:
- aclk, input, 1, clock; all state updates on the rising edge.
- aresetn, input, 1, asynchronous active-low reset.
- s_valid, input, 1, input transaction valid.
- s_ready, output, 1, block can accept an input this cycle.
- s_a, input, FP_W, operand A.
- s_b, input, FP_W, operand B.
- s_op, input, 3, predicate: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 UNORD, 7 ORD (each evaluated as A op B).
- m_valid, output, 1, output transaction valid.
- m_ready, input, 1, downstream accepts output.
- m_result, output, RESULT_W, predicate result in bit 0, zeros above.
- m_flags, output, 4, raw relation {unordered, gt, eq, lt}; exactly one bit is set when m_valid=1.

Behaviour:
- Reset:
  - While aresetn=0, all stage valid bits, m_valid, m_result and m_flags are 0, and s_ready is forced 0.
  - Reset assertion takes effect immediately (asynchronous). In-flight transactions are discarded, never emitted.
- Advance enable: en = !m_valid || m_ready. s_ready = en (when out of reset). An input transfers on an edge with s_valid && s_ready.
- Pipeline movement:
  - When en=1, every stage shifts one step. Stage 0 loads the input and sets its valid bit to s_valid.
  - When en=0, all stages hold. Bubbles are not collapsed.
- Latency: with m_ready held 1, an input accepted at edge k produces m_valid=1 after edge k+LATENCY-1, visible for one cycle.
- Output stability: while m_valid=1 and m_ready=0, m_result and m_flags hold stable. Order is strictly preserved.
- Stage split:
  - Stage 0 classifies both operands (NaN, zero) and computes sign-magnitude ordering.
  - The final stage decodes s_op against the relation. With LATENCY=1 this collapses into a single register.
  - Extra stages beyond 2 are pure delay registers inserted before the output.
- Classification:
  - NaN: exponent all-ones and mantissa non-zero (quiet or signalling, treated the same).
  - Zero: exponent and mantissa both zero; +0 and -0 compare equal.
  - Infinities are ordered normally.
  - Subnormals are compared by magnitude with no flushing.
- Ordering:
  - Both operands non-NaN, not both zero.
  - Signs differ: the negative operand is less.
  - Both positive: compare {exp, man} unsigned.
  - Both negative: the comparison is inverted.
- Predicate truth:
  - If either operand is NaN, the relation is unordered. EQ/LT/LE/GT/GE give 0, NE gives 1, UNORD gives 1, ORD gives 0.
  - Otherwise UNORD gives 0 and ORD gives 1.
- Simultaneous events: input accept and output drain on the same edge are legal and give full throughput of one transaction per cycle.

Decomposition:
- Package fp_cmp_pkg holds:
  - the op enum (fp_cmp_op_e with the 8 codes above);
  - flag bit index constants (FLG_LT=0, FLG_EQ=1, FLG_GT=2, FLG_UN=3);
  - a function computing FP_W from EXP_W and MAN_W.
- Sub-module fp_classify: combinational, parametrised by EXP_W/MAN_W. Outputs sign, is_nan, is_zero and a magnitude vector. It is instantiated twice in stage 0.

Test Plan:
- Default params, GE, A=3fc00000 (1.5), B=40200000 (2.5), m_ready=1 -> m_result=0 and m_flags=0001 after 2 edges. Swap the operands -> m_result=1, m_flags=0100.
- EQ, A=00000000, B=80000000 -> m_result=1, m_flags=0010. LT on the same operands -> 0.
- A=7fc00000 (NaN), B=3f800000: NE -> 1, GE -> 0, EQ -> 0, UNORD -> 1, ORD -> 0; m_flags=1000 in each case.
- Stream 6 back-to-back mixed ops with m_ready=0 for cycles 3-5:
  - s_ready drops while the output is held;
  - m_result/m_flags stay stable while stalled;
  - all 6 results emerge in order with none lost or duplicated.
- Reset mid-stream: assert aresetn=0 with 2 transactions in flight -> m_valid=0 immediately, outputs zero, s_ready=0. After release, s_ready=1 and no stale result appears.
- EXP_W=11, MAN_W=52, LATENCY=4:
  - LT, A=BFF0000000000000 (-1.0), B=7FF0000000000000 (+inf) -> 1 after 4 edges.
  - GT, A=0000000000000001 (min subnormal), B=0 -> 1.
  - LT, A=FFF0000000000000 (-inf), B=FFEFFFFFFFFFFFFF (-max) -> 1.

Source files
------------

// File: rtl/fp_cmp_pkg.sv
// Shared types for the floating-point comparator: predicate codes, relation flag layout,
// the stage record carried down the pipe, and the relation/predicate helper functions.
package fp_cmp_pkg;

  typedef enum logic [2:0] {
    OP_EQ    = 3'd0,
    OP_NE    = 3'd1,
    OP_LT    = 3'd2,
    OP_LE    = 3'd3,
    OP_GT    = 3'd4,
    OP_GE    = 3'd5,
    OP_UNORD = 3'd6,
    OP_ORD   = 3'd7
  } fp_cmp_op_e;

  localparam int FLG_LT = 0;
  localparam int FLG_EQ = 1;
  localparam int FLG_GT = 2;
  localparam int FLG_UN = 3;
  localparam int FLG_W  = 4;

  typedef struct packed {
    logic             vld;
    fp_cmp_op_e       op;
    logic [FLG_W-1:0] flg;
  } cmp_stage_t;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Negative operands order opposite to their magnitudes; +0/-0 meet in the both-zero case.
  function automatic logic [FLG_W-1:0] relation(
    input logic nan_a,  input logic nan_b,
    input logic zero_a, input logic zero_b,
    input logic sign_a, input logic sign_b,
    input logic mag_lt, input logic mag_eq
  );
    logic [FLG_W-1:0] rel;
    rel = '0;
    if (nan_a || nan_b) begin
      rel[FLG_UN] = 1'b1;
    end else if ((zero_a && zero_b) || ((sign_a == sign_b) && mag_eq)) begin
      rel[FLG_EQ] = 1'b1;
    end else if (sign_a != sign_b) begin
      if (sign_a) rel[FLG_LT] = 1'b1;
      else        rel[FLG_GT] = 1'b1;
    end else if (mag_lt ^ sign_a) begin
      rel[FLG_LT] = 1'b1;
    end else begin
      rel[FLG_GT] = 1'b1;
    end
    return rel;
  endfunction

  function automatic logic pred_eval(input fp_cmp_op_e op, input logic [FLG_W-1:0] flg);
    logic r;
    r = 1'b0;
    case (op)
      OP_EQ:    r = flg[FLG_EQ];
      OP_NE:    r = !flg[FLG_EQ];
      OP_LT:    r = flg[FLG_LT];
      OP_LE:    r = flg[FLG_LT] | flg[FLG_EQ];
      OP_GT:    r = flg[FLG_GT];
      OP_GE:    r = flg[FLG_GT] | flg[FLG_EQ];
      OP_UNORD: r = flg[FLG_UN];
      OP_ORD:   r = !flg[FLG_UN];
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: sign, NaN, zero and the unsigned {exp, man} magnitude.
// No latency, no flow control.
module fp_classify
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0]   x,
  output logic                   sign,
  output logic                   is_nan,
  output logic                   is_zero,
  output logic [EXP_W+MAN_W-1:0] mag
);

  localparam int FP_W  = fp_width(EXP_W, MAN_W);
  localparam int MAG_W = FP_W - 1;

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign sign    = x[FP_W-1];
  assign mag     = x[MAG_W-1:0];
  assign exp_f   = x[MAG_W-1:MAN_W];
  assign man_f   = x[MAN_W-1:0];
  // Infinity (all-ones exponent, zero fraction) is an ordinary ordered value.
  assign is_nan  = (&exp_f) && (|man_f);
  assign is_zero = ~|mag;

endmodule

// File: rtl/fp_compare_pipe.sv
// Pipelined IEEE-754 comparator, LATENCY edges from accept to m_valid.
// Whole pipe stalls (bubbles kept) while m_valid && !m_ready; s_ready mirrors the advance enable.
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int LATENCY  = 2,
  parameter int RESULT_W = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [EXP_W+MAN_W:0]   s_a,
  input  logic [EXP_W+MAN_W:0]   s_b,
  input  logic [2:0]             s_op,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [RESULT_W-1:0]    m_result,
  output logic [FLG_W-1:0]       m_flags
);

  localparam int FP_W  = fp_width(EXP_W, MAN_W);
  localparam int MAG_W = FP_W - 1;
  localparam int NPRE  = LATENCY - 1;

  logic             en;
  logic             sign_a, sign_b, nan_a, nan_b, zero_a, zero_b;
  logic [MAG_W-1:0] mag_a, mag_b;
  cmp_stage_t       cur_in;
  cmp_stage_t       fin_in;

  logic             out_vld_q, out_vld_d;
  logic             out_res_q, out_res_d;
  logic [FLG_W-1:0] out_flg_q, out_flg_d;

  assign en      = !out_vld_q || m_ready;
  assign s_ready = aresetn && en;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x       (s_a),
    .sign    (sign_a),
    .is_nan  (nan_a),
    .is_zero (zero_a),
    .mag     (mag_a)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x       (s_b),
    .sign    (sign_b),
    .is_nan  (nan_b),
    .is_zero (zero_b),
    .mag     (mag_b)
  );

  always_comb begin
    cur_in     = '0;
    cur_in.vld = s_valid;
    cur_in.op  = fp_cmp_op_e'(s_op);
    cur_in.flg = relation(nan_a, nan_b, zero_a, zero_b, sign_a, sign_b,
                          mag_a < mag_b, mag_a == mag_b);
  end

  // With one stage the relation feeds the output register directly; otherwise it is
  // registered in stage 0 and walks through any pure delay stages to the decode stage.
  if (LATENCY == 1) begin : g_direct
    assign fin_in = cur_in;
  end else begin : g_pipe
    cmp_stage_t pipe_q [NPRE];
    cmp_stage_t pipe_d [NPRE];

    always_comb begin
      for (int i = 0; i < NPRE; i++) begin
        pipe_d[i] = pipe_q[i];
      end
      if (en) begin
        pipe_d[0] = cur_in;
        for (int i = 1; i < NPRE; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        for (int i = 0; i < NPRE; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < NPRE; i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end

    assign fin_in = pipe_q[NPRE-1];
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_res_d = out_res_q;
    out_flg_d = out_flg_q;
    if (en) begin
      out_vld_d = fin_in.vld;
      out_res_d = fin_in.vld && pred_eval(fin_in.op, fin_in.flg);
      out_flg_d = fin_in.vld ? fin_in.flg : '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_vld_q <= 1'b0;
      out_res_q <= 1'b0;
      out_flg_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_res_q <= out_res_d;
      out_flg_q <= out_flg_d;
    end
  end

  assign m_valid = out_vld_q;
  assign m_flags = out_flg_q;

  always_comb begin
    m_result    = '0;
    m_result[0] = out_res_q;
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Bench for fp_compare_pipe: single-precision LATENCY=2 and double-precision LATENCY=4 instances,
// directed vector table, stall/reset sequences and randomized streams against an integer-key model.
module tb_fp_compare_pipe;

  logic        aclk;
  logic        rstn0, sv0, sr0, mv0, mr0;
  logic [31:0] a0, b0, res0;
  logic [2:0]  op0;
  logic [3:0]  flg0;
  logic        rstn1, sv1, sr1, mv1, mr1;
  logic [63:0] a1, b1;
  logic [31:0] res1;
  logic [2:0]  op1;
  logic [3:0]  flg1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    int          sel;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic        exp_r;
    logic [3:0]  exp_f;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } stim_t;

  vec_t        tbl[$];
  stim_t       stim_q[$];
  logic [4:0]  exp_q[$];

  fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(2), .RESULT_W(32)) u_dut0 (
    .aclk(aclk), .aresetn(rstn0), .s_valid(sv0), .s_ready(sr0), .s_a(a0), .s_b(b0),
    .s_op(op0), .m_valid(mv0), .m_ready(mr0), .m_result(res0), .m_flags(flg0)
  );

  fp_compare_pipe #(.EXP_W(11), .MAN_W(52), .LATENCY(4), .RESULT_W(32)) u_dut1 (
    .aclk(aclk), .aresetn(rstn1), .s_valid(sv1), .s_ready(sr1), .s_a(a1), .s_b(b1),
    .s_op(op1), .m_valid(mv1), .m_ready(mr1), .m_result(res1), .m_flags(flg1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a non-NaN value maps to the signed integer +/-magnitude, which orders IEEE
  // values exactly (both zeros map to 0).
  function automatic logic [3:0] ref_flags(input logic [63:0] a, input logic [63:0] b,
                                           input int ew, input int mw);
    logic [63:0] mmask, fmask, emax, ma, mb;
    logic        an, bn;
    longint      ka, kb;
    mmask = (64'd1 << (ew + mw)) - 64'd1;
    fmask = (64'd1 << mw) - 64'd1;
    emax  = (64'd1 << ew) - 64'd1;
    ma = a & mmask;
    mb = b & mmask;
    an = ((ma >> mw) == emax) && ((ma & fmask) != 0);
    bn = ((mb >> mw) == emax) && ((mb & fmask) != 0);
    ka = a[ew+mw] ? -longint'(ma) : longint'(ma);
    kb = b[ew+mw] ? -longint'(mb) : longint'(mb);
    if (an || bn) return 4'b1000;
    if (ka < kb)  return 4'b0001;
    if (ka == kb) return 4'b0010;
    return 4'b0100;
  endfunction

  function automatic logic ref_pred(input logic [2:0] op, input logic [3:0] fl);
    case (op)
      3'd0:    return fl[1];
      3'd1:    return !fl[1];
      3'd2:    return fl[0];
      3'd3:    return fl[0] || fl[1];
      3'd4:    return fl[2];
      3'd5:    return fl[2] || fl[1];
      3'd6:    return fl[3];
      default: return !fl[3];
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    logic        s;
    logic [31:0] w;
    s = 1'($urandom_range(0, 1));
    w = $urandom;
    case ($urandom_range(0, 7))
      0:       return {s, 31'h0};
      1:       return {s, 8'hff, 23'h0};
      2:       return {s, 8'hff, w[22:0] | 23'h1};
      3:       return {s, 8'h00, w[22:0]};
      4:       return {s, 8'h01, w[22:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    logic        s;
    logic [63:0] w;
    s = 1'($urandom_range(0, 1));
    w = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return {s, 63'h0};
      1:       return {s, 11'h7ff, 52'h0};
      2:       return {s, 11'h7ff, w[51:0] | 52'h1};
      3:       return {s, 11'h000, w[51:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [63:0] partner(input logic [63:0] a, input logic [63:0] sbit,
                                          input logic [63:0] other);
    case ($urandom_range(0, 7))
      0, 1:    return a;
      2:       return a ^ sbit;
      3:       return a + 64'd1;
      4:       return a - 64'd1;
      default: return other;
    endcase
  endfunction

  // Caller sits just after a rising edge; returns the edge count from accept to m_valid.
  task automatic run_one(input int sel, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] op, output logic [31:0] r, output logic [3:0] f,
                         output int edges);
    if (sel == 0) begin
      a0 = a[31:0]; b0 = b[31:0]; op0 = op; sv0 = 1'b1; mr0 = 1'b1;
    end else begin
      a1 = a; b1 = b; op1 = op; sv1 = 1'b1; mr1 = 1'b1;
    end
    @(posedge aclk); #1;
    sv0 = 1'b0;
    sv1 = 1'b0;
    edges = 1;
    while (!((sel == 0) ? mv0 : mv1) && edges < 20) begin
      @(posedge aclk); #1;
      edges++;
    end
    r = (sel == 0) ? res0 : res1;
    f = (sel == 0) ? flg0 : flg1;
  endtask

  // Streams stim_q through DUT0; m_ready low in cycles [stall_lo, stall_hi] or random when rnd.
  task automatic stream0(input int stall_lo, input int stall_hi, input bit rnd,
                         input int budget, output int n_out);
    int          cyc;
    logic        fire_in;
    logic [3:0]  fl;
    stim_t       s;
    cyc   = 0;
    n_out = 0;
    sv0   = 1'b0;
    while ((stim_q.size() > 0 || exp_q.size() > 0 || sv0) && cyc < budget) begin
      if (!sv0 && stim_q.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
        s = stim_q.pop_front();
        a0 = s.a; b0 = s.b; op0 = s.op; sv0 = 1'b1;
      end
      mr0 = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
      @(negedge aclk);
      if (mv0 && !mr0) chk("s_ready_stall", {63'b0, sr0}, 64'd0);
      else             chk("s_ready_open",  {63'b0, sr0}, 64'd1);
      if (mv0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          chk("stream_res",   {32'b0, res0}, {59'b0, exp_q[0][4]});
          chk("stream_flags", {60'b0, flg0}, {60'b0, exp_q[0][3:0]});
          if (mr0) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      fire_in = sv0 && sr0;
      if (fire_in) begin
        fl = ref_flags({32'b0, a0}, {32'b0, b0}, 8, 23);
        exp_q.push_back({ref_pred(op0, fl), fl});
      end
      @(posedge aclk); #1;
      if (fire_in) sv0 = 1'b0;
      cyc++;
    end
    sv0 = 1'b0;
    mr0 = 1'b1;
    chk("stream_complete", 64'(stim_q.size() + exp_q.size()), 64'd0);
    stim_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    logic [63:0] ra, rb;
    logic [2:0]  rop;
    int          edges, n_out, seen;

    tbl = '{
      '{0, 64'h3fc00000, 64'h40200000, 3'd5, 1'b0, 4'b0001},
      '{0, 64'h40200000, 64'h3fc00000, 3'd5, 1'b1, 4'b0100},
      '{0, 64'h00000000, 64'h80000000, 3'd0, 1'b1, 4'b0010},
      '{0, 64'h00000000, 64'h80000000, 3'd2, 1'b0, 4'b0010},
      '{0, 64'h80000000, 64'h00000000, 3'd3, 1'b1, 4'b0010},
      '{0, 64'h7fc00000, 64'h3f800000, 3'd1, 1'b1, 4'b1000},
      '{0, 64'h7fc00000, 64'h3f800000, 3'd5, 1'b0, 4'b1000},
      '{0, 64'h7fc00000, 64'h3f800000, 3'd0, 1'b0, 4'b1000},
      '{0, 64'h7fc00000, 64'h3f800000, 3'd6, 1'b1, 4'b1000},
      '{0, 64'h7fc00000, 64'h3f800000, 3'd7, 1'b0, 4'b1000},
      '{0, 64'h7f800000, 64'h7f800000, 3'd0, 1'b1, 4'b0010},
      '{0, 64'hbf800000, 64'hbf000000, 3'd2, 1'b1, 4'b0001},
      '{0, 64'h00000001, 64'h80000001, 3'd4, 1'b1, 4'b0100},
      '{1, 64'hbff0000000000000, 64'h7ff0000000000000, 3'd2, 1'b1, 4'b0001},
      '{1, 64'h0000000000000001, 64'h0000000000000000, 3'd4, 1'b1, 4'b0100},
      '{1, 64'hfff0000000000000, 64'hffefffffffffffff, 3'd2, 1'b1, 4'b0001},
      '{1, 64'h7ff8000000000000, 64'h7ff8000000000000, 3'd1, 1'b1, 4'b1000}
    };

    rstn0 = 1'b0; rstn1 = 1'b0;
    sv0 = 1'b1; mr0 = 1'b1; a0 = '0; b0 = '0; op0 = '0;
    sv1 = 1'b0; mr1 = 1'b1; a1 = '0; b1 = '0; op1 = '0;
    repeat (2) @(negedge aclk);
    chk("rst_m_valid0",  {63'b0, mv0}, 64'd0);
    chk("rst_m_result0", {32'b0, res0}, 64'd0);
    chk("rst_m_flags0",  {60'b0, flg0}, 64'd0);
    chk("rst_s_ready0",  {63'b0, sr0}, 64'd0);
    chk("rst_m_valid1",  {63'b0, mv1}, 64'd0);
    chk("rst_s_ready1",  {63'b0, sr1}, 64'd0);
    @(posedge aclk); #1;
    sv0 = 1'b0;
    rstn0 = 1'b1; rstn1 = 1'b1;
    #1;
    chk("post_rst_s_ready0", {63'b0, sr0}, 64'd1);
    chk("post_rst_s_ready1", {63'b0, sr1}, 64'd1);
    @(posedge aclk); #1;

    foreach (tbl[i]) begin
      run_one(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].op, r, f, edges);
      chk($sformatf("vec%0d_latency", i), 64'(edges), (tbl[i].sel == 0) ? 64'd2 : 64'd4);
      chk($sformatf("vec%0d_result", i), {32'b0, r}, {63'b0, tbl[i].exp_r});
      chk($sformatf("vec%0d_flags", i), {60'b0, f}, {60'b0, tbl[i].exp_f});
    end

    // Six back-to-back transfers with m_ready low for cycles 3-5.
    stim_q.push_back('{32'h3fc00000, 32'h40200000, 3'd5});
    stim_q.push_back('{32'h3fc00000, 32'h40200000, 3'd2});
    stim_q.push_back('{32'h00000000, 32'h80000000, 3'd0});
    stim_q.push_back('{32'h7fc00000, 32'h3f800000, 3'd1});
    stim_q.push_back('{32'h7f800000, 32'h7f7fffff, 3'd4});
    stim_q.push_back('{32'h7fc00000, 32'h3f800000, 3'd7});
    stream0(3, 5, 1'b0, 60, n_out);
    chk("stall_out_count", 64'(n_out), 64'd6);

    // Reset with two transactions in flight.
    a0 = 32'h00000000; b0 = 32'h00000000; op0 = 3'd0; sv0 = 1'b1; mr0 = 1'b1;
    @(posedge aclk); #1;
    a0 = 32'h3f800000; b0 = 32'h40000000; op0 = 3'd2;
    @(posedge aclk); #1;
    sv0 = 1'b0;
    chk("pre_rst_m_valid", {63'b0, mv0}, 64'd1);
    #2 rstn0 = 1'b0;
    #1;
    chk("mid_rst_m_valid",  {63'b0, mv0}, 64'd0);
    chk("mid_rst_m_result", {32'b0, res0}, 64'd0);
    chk("mid_rst_m_flags",  {60'b0, flg0}, 64'd0);
    chk("mid_rst_s_ready",  {63'b0, sr0}, 64'd0);
    repeat (2) @(posedge aclk);
    #1 rstn0 = 1'b1;
    #1 chk("rel_rst_s_ready", {63'b0, sr0}, 64'd1);
    seen = 0;
    repeat (6) begin
      @(negedge aclk);
      if (mv0) seen++;
    end
    chk("no_stale_after_rst", 64'(seen), 64'd0);
    @(posedge aclk); #1;

    for (int i = 0; i < 300; i++) begin
      ra = {32'b0, rnd32()};
      rb = partner(ra, 64'h80000000, {32'b0, rnd32()});
      stim_q.push_back('{ra[31:0], rb[31:0], 3'($urandom_range(0, 7))});
    end
    stream0(-1, -1, 1'b1, 3000, n_out);
    chk("rand_out_count", 64'(n_out), 64'd300);

    for (int i = 0; i < 30; i++) begin
      ra  = rnd64();
      rb  = partner(ra, 64'h8000000000000000, rnd64());
      rop = 3'($urandom_range(0, 7));
      run_one(1, ra, rb, rop, r, f, edges);
      f = ref_flags(ra, rb, 11, 52);
      chk($sformatf("dp_rand%0d_result", i), {32'b0, r}, {63'b0, ref_pred(rop, f)});
      chk($sformatf("dp_rand%0d_flags", i), {60'b0, flg1}, {60'b0, f});
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
